// File: rtl/pkt_cache_slot_mgmt.sv
// pkt_cache_slot_mgmt: slot allocator and FIFO scheduler for the 2048x134
// packet cache RAM. The RAM is split into SLOT_NUM slots of SLOT_DEPTH words.
// Free slot indices live in a free FIFO. Each completed packet's index moves to
// a send FIFO. Packets are then issued to the reader one at a time, in order.
// Optional statistics ports are enabled by defining SLOT_MGMT_STAT_EN.
module pkt_cache_slot_mgmt #(
  parameter int SLOT_NUM   = 64,
  parameter int SLOT_DEPTH = 32,
  parameter int ADDR_W     = 11,
  parameter int IDX_W      = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_pkt_req,
  input  logic              in_pkt_done,
  input  logic              in_rd_done,
  output logic [ADDR_W-1:0] addr2data_waddr,
  output logic              addr2data_waddr_wr,
  output logic [ADDR_W-1:0] addr2data_raddr,
  output logic              addr2data_raddr_wr,
  output logic              out_pkt_drop,
  output logic              out_ready,
  output logic [IDX_W:0]    out_free_cnt,
  output logic [31:0]       out_drop_cnt
);

  localparam int OFF_W = $clog2(SLOT_DEPTH);

  localparam logic [0:0] W_IDLE  = 1'b0;
  localparam logic [0:0] W_BUSY  = 1'b1;
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;

  function automatic logic [ADDR_W-1:0] slot_base(input logic [IDX_W-1:0] idx);
    return ADDR_W'(idx) << OFF_W;
  endfunction

  // Free FIFO storage and pointers.
  logic [IDX_W-1:0] free_mem_q [SLOT_NUM];
  logic [IDX_W-1:0] free_wp_q, free_wp_d, free_rp_q, free_rp_d;
  logic [IDX_W:0]   free_cnt_q, free_cnt_d;
  logic             free_push, free_pop;
  logic [IDX_W-1:0] free_push_idx;

  // Send FIFO storage and pointers.
  logic [IDX_W-1:0] send_mem_q [SLOT_NUM];
  logic [IDX_W-1:0] send_wp_q, send_wp_d, send_rp_q, send_rp_d;
  logic [IDX_W:0]   send_cnt_q, send_cnt_d;
  logic             send_push, send_pop;

  // Control state.
  logic             ready_q, ready_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [0:0]       w_state_q, w_state_d;
  logic [1:0]       r_state_q, r_state_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic             waddr_wr_q, waddr_wr_d, raddr_wr_q, raddr_wr_d;
  logic             drop_q, drop_d;

  // Next-state logic for INIT fill, write FSM, read FSM and both FIFOs.
  always_comb begin
    ready_d       = ready_q;
    init_cnt_d    = init_cnt_q;
    w_state_d     = w_state_q;
    r_state_d     = r_state_q;
    widx_d        = widx_q;
    ridx_d        = ridx_q;
    waddr_d       = waddr_q;
    raddr_d       = raddr_q;
    waddr_wr_d    = 1'b0;
    raddr_wr_d    = 1'b0;
    drop_d        = 1'b0;
    free_push     = 1'b0;
    free_pop      = 1'b0;
    free_push_idx = '0;
    send_push     = 1'b0;
    send_pop      = 1'b0;

    if (!ready_q) begin
      free_push     = 1'b1;
      free_push_idx = init_cnt_q;
      init_cnt_d    = init_cnt_q + 1'b1;
      drop_d        = in_pkt_req;
      if (init_cnt_q == IDX_W'(SLOT_NUM - 1)) begin
        ready_d = 1'b1;
      end
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (in_pkt_req) begin
            // Emptiness is judged on the registered count, so a slot returned
            // in this same cycle cannot satisfy this request.
            if (free_cnt_q != '0) begin
              free_pop   = 1'b1;
              widx_d     = free_mem_q[free_rp_q];
              waddr_d    = slot_base(free_mem_q[free_rp_q]);
              waddr_wr_d = 1'b1;
              w_state_d  = W_BUSY;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
        default: begin
          if (in_pkt_req) begin
            drop_d = 1'b1;
          end
          if (in_pkt_done) begin
            send_push = 1'b1;
            w_state_d = W_IDLE;
          end
        end
      endcase

      case (r_state_q)
        R_IDLE: begin
          if (send_cnt_q != '0) begin
            send_pop   = 1'b1;
            ridx_d     = send_mem_q[send_rp_q];
            raddr_d    = slot_base(send_mem_q[send_rp_q]);
            raddr_wr_d = 1'b1;
            r_state_d  = R_ISSUE;
          end
        end
        R_ISSUE: begin
          r_state_d = R_WAIT;
        end
        R_WAIT: begin
          if (in_rd_done) begin
            free_push     = 1'b1;
            free_push_idx = ridx_q;
            r_state_d     = R_IDLE;
          end
        end
        default: begin
          r_state_d = R_IDLE;
        end
      endcase
    end

    free_wp_d  = free_push ? free_wp_q + 1'b1 : free_wp_q;
    free_rp_d  = free_pop  ? free_rp_q + 1'b1 : free_rp_q;
    free_cnt_d = free_cnt_q + (IDX_W+1)'(free_push) - (IDX_W+1)'(free_pop);
    send_wp_d  = send_push ? send_wp_q + 1'b1 : send_wp_q;
    send_rp_d  = send_pop  ? send_rp_q + 1'b1 : send_rp_q;
    send_cnt_d = send_cnt_q + (IDX_W+1)'(send_push) - (IDX_W+1)'(send_pop);
  end

  // Control and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q    <= 1'b0;
      init_cnt_q <= '0;
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      widx_q     <= '0;
      ridx_q     <= '0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      waddr_wr_q <= 1'b0;
      raddr_wr_q <= 1'b0;
      drop_q     <= 1'b0;
      free_wp_q  <= '0;
      free_rp_q  <= '0;
      free_cnt_q <= '0;
      send_wp_q  <= '0;
      send_rp_q  <= '0;
      send_cnt_q <= '0;
    end else begin
      ready_q    <= ready_d;
      init_cnt_q <= init_cnt_d;
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      widx_q     <= widx_d;
      ridx_q     <= ridx_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      waddr_wr_q <= waddr_wr_d;
      raddr_wr_q <= raddr_wr_d;
      drop_q     <= drop_d;
      free_wp_q  <= free_wp_d;
      free_rp_q  <= free_rp_d;
      free_cnt_q <= free_cnt_d;
      send_wp_q  <= send_wp_d;
      send_rp_q  <= send_rp_d;
      send_cnt_q <= send_cnt_d;
    end
  end

  // FIFO storage writes; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk) begin
    if (!rst && free_push) begin
      free_mem_q[free_wp_q] <= free_push_idx;
    end
    if (!rst && send_push) begin
      send_mem_q[send_wp_q] <= widx_q;
    end
  end

  assign addr2data_waddr    = waddr_q;
  assign addr2data_waddr_wr = waddr_wr_q;
  assign addr2data_raddr    = raddr_q;
  assign addr2data_raddr_wr = raddr_wr_q;
  assign out_pkt_drop       = drop_q;
  assign out_ready          = ready_q;

`ifdef SLOT_MGMT_STAT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of refused requests, updated together with the drop pulse.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Occupancy reads 0 while the free list is still being filled.
  assign out_free_cnt = ready_q ? free_cnt_q : '0;
  assign out_drop_cnt = drop_cnt_q;
`else
  assign out_free_cnt = '0;
  assign out_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_cache_slot_mgmt.sv
// Scoreboard bench for pkt_cache_slot_mgmt: directed stimulus pushes expected
// strobes (cycle + address) into queues; a negedge monitor pops and compares.
module tb_pkt_cache_slot_mgmt;

`ifdef SLOT_MGMT_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_pkt_req = 1'b0, in_pkt_done = 1'b0, in_rd_done = 1'b0;
  logic [10:0] waddr, raddr;
  logic        waddr_wr, raddr_wr, pkt_drop, ready;
  logic [6:0]  free_cnt;
  logic [31:0] drop_cnt;

  pkt_cache_slot_mgmt #(.SLOT_NUM(64), .SLOT_DEPTH(32), .ADDR_W(11), .IDX_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_pkt_req(in_pkt_req), .in_pkt_done(in_pkt_done), .in_rd_done(in_rd_done),
    .addr2data_waddr(waddr), .addr2data_waddr_wr(waddr_wr),
    .addr2data_raddr(raddr), .addr2data_raddr_wr(raddr_wr),
    .out_pkt_drop(pkt_drop), .out_ready(ready),
    .out_free_cnt(free_cnt), .out_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {int cyc; logic [10:0] addr;} exp_t;
  exp_t wq[$];
  exp_t rq[$];
  int   dq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_w(input int c, input int a);
    exp_t e;
    e.cyc = c; e.addr = 11'(a);
    wq.push_back(e);
  endtask

  task automatic exp_r(input int c, input int a);
    exp_t e;
    e.cyc = c; e.addr = 11'(a);
    rq.push_back(e);
  endtask

  // One cycle of stimulus; entered and left at #1 after a rising edge.
  task automatic step(input logic r, input logic d, input logic rd);
    in_pkt_req = r; in_pkt_done = d; in_rd_done = rd;
    @(posedge clk); #1;
    in_pkt_req = 1'b0; in_pkt_done = 1'b0; in_rd_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin : monitor
    exp_t e;
    int   dc;
    if (waddr_wr) begin
      if (wq.size() == 0) chk("waddr_wr_unexpected", 32'(waddr_wr), 32'd0);
      else begin
        e = wq.pop_front();
        chk("waddr_cycle", 32'(cyc), 32'(e.cyc));
        chk("waddr", 32'(waddr), 32'(e.addr));
      end
    end
    if (raddr_wr) begin
      if (rq.size() == 0) chk("raddr_wr_unexpected", 32'(raddr_wr), 32'd0);
      else begin
        e = rq.pop_front();
        chk("raddr_cycle", 32'(cyc), 32'(e.cyc));
        chk("raddr", 32'(raddr), 32'(e.addr));
      end
    end
    if (pkt_drop) begin
      if (dq.size() == 0) chk("drop_unexpected", 32'(pkt_drop), 32'd0);
      else begin
        dc = dq.pop_front();
        chk("drop_cycle", 32'(cyc), 32'(dc));
      end
    end
  end

  // Reset, then walk INIT checking ready timing; optionally poke inputs during INIT.
  task automatic do_reset(input bit poke);
    int r0;
    rst = 1'b1;
    idle(2);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_waddr_wr", 32'(waddr_wr), 32'd0);
    chk("rst_raddr_wr", 32'(raddr_wr), 32'd0);
    chk("rst_drop", 32'(pkt_drop), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_free_cnt", 32'(free_cnt), 32'd0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    rst = 1'b0;
    r0 = cyc;
    for (int i = 0; i < 64; i++) begin
      chk("init_ready_low", 32'(ready), 32'd0);
      chk("init_free_cnt", 32'(free_cnt), 32'd0);
      if (poke && i == 10) begin
        dq.push_back(cyc + 1);
        step(1'b1, 1'b0, 1'b0);
      end else if (poke && i == 20) begin
        step(1'b0, 1'b1, 1'b1);
      end else begin
        step(1'b0, 1'b0, 1'b0);
      end
    end
    chk("init_ready_cycles", 32'(cyc - r0), 32'd64);
    chk("init_ready_high", 32'(ready), 32'd1);
    chk("init_free_cnt_full", 32'(free_cnt), STAT ? 32'd64 : 32'd0);
    if (poke) chk("init_drop_cnt", drop_cnt, STAT ? 32'd1 : 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    @(posedge clk); #1;

    // Reset/INIT with a refused request and ignored done/rd_done.
    do_reset(1'b1);

    // Single packet through slot 0.
    exp_w(cyc + 1, 'h000);
    step(1'b1, 1'b0, 1'b0);
    idle(4);
    chk("t2_free_cnt_busy", 32'(free_cnt), STAT ? 32'd63 : 32'd0);
    exp_r(cyc + 2, 'h000);
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    idle(1);
    chk("t2_free_cnt_back", 32'(free_cnt), STAT ? 32'd64 : 32'd0);

    // Reader in R_WAIT on slot 1, writer in W_BUSY on slot 2, then reset.
    exp_w(cyc + 1, 'h020);
    step(1'b1, 1'b0, 1'b0);
    exp_r(cyc + 2, 'h020);
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    exp_w(cyc + 1, 'h040);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    do_reset(1'b0);
    chk("t6_drop_cnt_cleared", drop_cnt, 32'd0);

    // Three packets, slots 0,1,2, read strictly one at a time in order.
    exp_w(cyc + 1, 'h000);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    exp_r(cyc + 2, 'h000);
    step(1'b0, 1'b1, 1'b0);
    exp_w(cyc + 1, 'h020);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    exp_w(cyc + 1, 'h040);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(3);
    exp_r(cyc + 2, 'h020);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    exp_r(cyc + 2, 'h040);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    chk("t5_free_cnt", 32'(free_cnt), STAT ? 32'd64 : 32'd0);

    // Exhaust all 64 slots (free order now 3..63,0,1,2); reader holds slot 3.
    for (int i = 0; i < 64; i++) begin
      exp_w(cyc + 1, ((i + 3) % 64) * 32);
      step(1'b1, 1'b0, 1'b0);
      if (i == 0) exp_r(cyc + 2, 3 * 32);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("t3_free_cnt_empty", 32'(free_cnt), 32'd0);
    dq.push_back(cyc + 1);
    step(1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t3_drop_cnt", drop_cnt, STAT ? 32'd1 : 32'd0);

    // Empty free list: rd_done and req together -> dropped, next req gets slot 3.
    dq.push_back(cyc + 1);
    exp_r(cyc + 2, 4 * 32);
    step(1'b1, 1'b0, 1'b1);
    exp_w(cyc + 1, 3 * 32);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("t4_drop_cnt", drop_cnt, STAT ? 32'd2 : 32'd0);

    // Drain everything; issue order follows completion order.
    for (int j = 0; j < 64; j++) begin
      if (j < 63) exp_r(cyc + 2, ((j + 5) % 64) * 32);
      step(1'b0, 1'b0, 1'b1);
      idle(2);
    end
    idle(4);
    chk("drain_free_cnt", 32'(free_cnt), STAT ? 32'd64 : 32'd0);
    chk("wq_leftover", 32'(wq.size()), 32'd0);
    chk("rq_leftover", 32'(rq.size()), 32'd0);
    chk("dq_leftover", 32'(dq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
